// File: rtl/tx_ordering_scheduler_if.sv
// Handshake bundle between request sources, the ordering scheduler
// and the TX arbiter.
interface tx_ordering_scheduler_if #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 16,
    parameter int TAG_W = 8
);
    localparam int OW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_class;
    logic             in_ro;
    logic             in_ido;
    logic [ID_W-1:0]  in_id;
    logic             in_comp_typ;
    logic [TAG_W-1:0] in_tag;
    logic [2:0]       credit_ok;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_class;
    logic [TAG_W-1:0] out_tag;
    logic             out_bypass;
    logic [OW-1:0]    occupancy;

    modport master (
        output in_valid, in_class, in_ro, in_ido, in_id,
        output in_comp_typ, in_tag, credit_ok, out_ready,
        input  in_ready, out_valid, out_class, out_tag,
        input  out_bypass, occupancy
    );

    modport slave (
        input  in_valid, in_class, in_ro, in_ido, in_id,
        input  in_comp_typ, in_tag, credit_ok, out_ready,
        output in_ready, out_valid, out_class, out_tag,
        output out_bypass, occupancy
    );
endinterface

// File: rtl/tx_ordering_scheduler.sv
// Age-ordered, credit-aware TLP scheduler applying PCIe pass rules
// with a bounded bypass count protecting the head entry.
module tx_ordering_scheduler #(
    parameter int DEPTH      = 8,
    parameter int ID_W       = 16,
    parameter int TAG_W      = 8,
    parameter int MAX_BYPASS = 4
) (
    input logic                    clk,
    input logic                    arst,
    tx_ordering_scheduler_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int BW = (MAX_BYPASS > 0) ? $clog2(MAX_BYPASS + 1) : 1;

    localparam logic [1:0] C_P   = 2'b01;
    localparam logic [1:0] C_NP  = 2'b10;
    localparam logic [1:0] C_CPL = 2'b11;

    typedef struct packed {
        logic [1:0]       cls;
        logic             ro;
        logic             ido;
        logic [ID_W-1:0]  id;
        logic             comp_typ;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    logic [DEPTH-1:0] val_q, val_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [BW-1:0]    byp_q, byp_d;

    logic [DEPTH-1:0] elig;
    logic             gnt;
    logic [IW-1:0]    gnt_idx;
    logic             push, pop;
    logic [IW-1:0]    wr_idx;
    ent_t             new_e;

    function automatic logic has_credit(logic [1:0] c, logic [2:0] cr);
        case (c)
            C_P:     return cr[0];
            C_NP:    return cr[1];
            C_CPL:   return cr[2];
            default: return 1'b0;
        endcase
    endfunction

    // May younger y overtake older o?
    function automatic logic pass_f(ent_t o, ent_t y);
        logic rop, idp;
        rop = o.ro && y.ro;
        idp = o.ido && y.ido && (o.id != y.id);
        if (y.cls == C_CPL) begin
            case (o.cls)
                C_P:     return rop || y.comp_typ || idp;
                C_CPL:   return o.id != y.id;
                default: return 1'b1;
            endcase
        end
        return (o.cls == C_P) ? (rop || idp) : 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = val_q[i] && has_credit(ent_q[i].cls, bus.credit_ok);
            for (int j = 0; j < i; j++) begin
                if (val_q[j] && !pass_f(ent_q[j], ent_q[i])) elig[i] = 1'b0;
            end
        end
    end

    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        if (byp_q == BW'(MAX_BYPASS)) begin
            gnt = elig[0];
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    gnt     = 1'b1;
                    gnt_idx = IW'(i);
                end
            end
        end
    end

    assign bus.in_ready   = (occ_q != OW'(DEPTH));
    assign bus.out_valid  = gnt;
    assign bus.out_class  = gnt ? ent_q[gnt_idx].cls : 2'b00;
    assign bus.out_tag    = gnt ? ent_q[gnt_idx].tag : '0;
    assign bus.out_bypass = gnt && (gnt_idx != '0);
    assign bus.occupancy  = occ_q;

    assign push   = bus.in_valid && bus.in_ready;
    assign pop    = gnt && bus.out_ready;
    assign wr_idx = IW'(occ_q) - IW'(pop);
    assign new_e  = {bus.in_class, bus.in_ro, bus.in_ido, bus.in_id,
                     bus.in_comp_typ, bus.in_tag};

    always_comb begin
        ent_d = ent_q;
        val_d = val_q;
        occ_d = occ_q + OW'(push) - OW'(pop);
        byp_d = byp_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(gnt_idx)) begin
                    ent_d[i] = ent_q[i+1];
                    val_d[i] = val_q[i+1];
                end
            end
            val_d[DEPTH-1] = 1'b0;
            if (gnt_idx == '0)
                byp_d = '0;
            else if (byp_q != BW'(MAX_BYPASS))
                byp_d = byp_q + BW'(1);
        end
        // Tail write lands after the shift so age order holds
        if (push) begin
            ent_d[wr_idx] = new_e;
            val_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            val_q <= '0;
            occ_q <= '0;
            byp_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            val_q <= val_d;
            occ_q <= occ_d;
            byp_q <= byp_d;
            ent_q <= ent_d;
        end
    end
endmodule

// File: tb/tb_tx_ordering_scheduler.sv
// Scenario bench for the ordering scheduler with an expected-grant
// queue filled as stimulus is driven.
module tb_tx_ordering_scheduler;
    localparam logic [1:0] P   = 2'b01;
    localparam logic [1:0] NP  = 2'b10;
    localparam logic [1:0] CPL = 2'b11;

    typedef struct packed {
        logic [1:0] c;
        logic [7:0] t;
        logic       b;
    } exp_t;

    logic clk = 1'b0;
    logic arst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    tx_ordering_scheduler_if #(.DEPTH(8), .ID_W(16), .TAG_W(8)) bus ();

    tx_ordering_scheduler #(
        .DEPTH(8), .ID_W(16), .TAG_W(8), .MAX_BYPASS(2)
    ) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus)
    );

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_class    = 2'b00;
        bus.in_ro       = 1'b0;
        bus.in_ido      = 1'b0;
        bus.in_id       = '0;
        bus.in_comp_typ = 1'b0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        exp_q.delete();
        arst = 1'b1;
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    task automatic push_e(input logic [1:0] c, input logic ro,
                          input logic ido, input logic [15:0] id,
                          input logic ct, input logic [7:0] tag);
        bus.in_valid    = 1'b1;
        bus.in_class    = c;
        bus.in_ro       = ro;
        bus.in_ido      = ido;
        bus.in_id       = id;
        bus.in_comp_typ = ct;
        bus.in_tag      = tag;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_one(output logic [1:0] c, output logic [7:0] t,
                           output logic b, output logic ok);
        ok = 1'b0;
        c = 2'b00;
        t = 8'h00;
        b = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                c  = bus.out_class;
                t  = bus.out_tag;
                b  = bus.out_bypass;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        logic [1:0] c;
        logic [7:0] t;
        logic       b, ok;
        exp_t       e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_one(c, t, b, ok);
            checks++;
            if (!ok || {c, t, b} !== {e.c, e.t, e.b}) begin
                errors++;
                $display("FAIL %s: got ok=%0b cls=%0d tag=%0d byp=%0b want cls=%0d tag=%0d byp=%0b",
                         name, ok, c, t, b, e.c, e.t, e.b);
            end
        end
    endtask

    task automatic stall_check(input string name, input int n);
        repeat (n) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s: out_valid=%0b want 0 tag=%0d", name,
                         bus.out_valid, bus.out_tag);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.credit_ok = 3'b111;
        arst = 1'b1;
        #1;
        checks++;
        if ({bus.occupancy, bus.out_valid, bus.out_bypass, bus.out_class, bus.out_tag}
            !== 17'd0) begin
            errors++;
            $display("FAIL reset_outs: occ=%0d ov=%0b byp=%0b cls=%0d tag=%0d want all 0",
                     bus.occupancy, bus.out_valid, bus.out_bypass, bus.out_class, bus.out_tag);
        end
        @(posedge clk);
        #1;
        arst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        bus.credit_ok = 3'b111;
        bus.in_valid = 1'b1;
        bus.in_class = P;
        bus.in_tag = 8'd0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_comb_path: out_valid=%0b want 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        push_e(NP, 0, 0, 16'd0, 0, 8'd1);
        checks++;
        if (bus.occupancy !== 4'd2) begin
            errors++;
            $display("FAIL in_order_occ: got %0d want 2", bus.occupancy);
        end
        exp_q.push_back('{P, 8'd0, 1'b0});
        exp_q.push_back('{NP, 8'd1, 1'b0});
        drain("in_order");
    endtask

    task automatic test_credit_bypass();
        do_reset();
        bus.credit_ok = 3'b110;
        push_e(P, 0, 1, 16'd5, 0, 8'd10);
        push_e(NP, 0, 1, 16'd7, 0, 8'd11);
        exp_q.push_back('{NP, 8'd11, 1'b1});
        drain("credit_bypass");
        stall_check("credit_wait", 2);
        bus.credit_ok = 3'b111;
        exp_q.push_back('{P, 8'd10, 1'b0});
        drain("credit_return");
    endtask

    task automatic test_cpl_order();
        do_reset();
        bus.credit_ok = 3'b011;
        push_e(CPL, 0, 0, 16'd3, 0, 8'd20);
        push_e(CPL, 0, 0, 16'd3, 0, 8'd21);
        push_e(P, 0, 0, 16'd9, 0, 8'd22);
        exp_q.push_back('{P, 8'd22, 1'b1});
        drain("cpl_p_first");
        stall_check("cpl_no_credit", 2);
        bus.credit_ok = 3'b111;
        exp_q.push_back('{CPL, 8'd20, 1'b0});
        exp_q.push_back('{CPL, 8'd21, 1'b0});
        drain("cpl_same_id");
    endtask

    task automatic test_cpl_pass_posted();
        do_reset();
        bus.credit_ok = 3'b100;
        push_e(P, 0, 0, 16'd1, 0, 8'd30);
        push_e(CPL, 0, 0, 16'd2, 1, 8'd31);
        push_e(CPL, 0, 0, 16'd3, 0, 8'd32);
        exp_q.push_back('{CPL, 8'd31, 1'b1});
        drain("cpl_comp_typ");
        stall_check("cpl_blocked", 2);
        bus.credit_ok = 3'b111;
        exp_q.push_back('{P, 8'd30, 1'b0});
        exp_q.push_back('{CPL, 8'd32, 1'b0});
        drain("cpl_after_p");
    endtask

    task automatic test_max_bypass();
        do_reset();
        bus.credit_ok = 3'b110;
        push_e(P, 1, 0, 16'd0, 0, 8'd40);
        push_e(NP, 1, 0, 16'd0, 0, 8'd41);
        push_e(NP, 1, 0, 16'd0, 0, 8'd42);
        push_e(P, 1, 0, 16'd0, 0, 8'd43);
        push_e(NP, 1, 0, 16'd0, 0, 8'd44);
        exp_q.push_back('{NP, 8'd41, 1'b1});
        exp_q.push_back('{NP, 8'd42, 1'b1});
        drain("bypass_two");
        stall_check("bypass_limit", 3);
        bus.credit_ok = 3'b111;
        exp_q.push_back('{P, 8'd40, 1'b0});
        drain("head_release");
        bus.credit_ok = 3'b110;
        exp_q.push_back('{NP, 8'd44, 1'b1});
        drain("bypass_cleared");
        bus.credit_ok = 3'b111;
        exp_q.push_back('{P, 8'd43, 1'b0});
        drain("bypass_tail");
    endtask

    task automatic test_full_middle();
        logic [7:0] tg;
        do_reset();
        bus.credit_ok = 3'b010;
        for (int i = 0; i < 8; i++) begin
            tg = 8'(50 + i);
            if (i < 4) push_e(CPL, 0, 0, 16'(i + 1), 0, tg);
            else       push_e(NP, 0, 0, 16'd0, 0, tg);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.occupancy !== 4'd8) begin
            errors++;
            $display("FAIL full: in_ready=%0b occ=%0d want 0/8",
                     bus.in_ready, bus.occupancy);
        end
        exp_q.push_back('{NP, 8'd54, 1'b1});
        drain("pop_middle");
        checks++;
        if (bus.in_ready !== 1'b1 || bus.occupancy !== 4'd7) begin
            errors++;
            $display("FAIL after_mid_pop: in_ready=%0b occ=%0d want 1/7",
                     bus.in_ready, bus.occupancy);
        end
        bus.credit_ok = 3'b111;
        for (int i = 0; i < 8; i++) begin
            if (i < 4)       exp_q.push_back('{CPL, 8'(50 + i), 1'b0});
            else if (i != 4) exp_q.push_back('{NP, 8'(50 + i), 1'b0});
        end
        drain("shift_order");
    endtask

    task automatic test_reset_flush();
        do_reset();
        bus.credit_ok = 3'b111;
        for (int i = 0; i < 5; i++) push_e(NP, 0, 0, 16'd0, 0, 8'(60 + i));
        checks++;
        if (bus.occupancy !== 4'd5 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush: occ=%0d ov=%0b want 5/1",
                     bus.occupancy, bus.out_valid);
        end
        arst = 1'b1;
        #1;
        checks++;
        if (bus.occupancy !== 4'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush: occ=%0d ov=%0b want 0/0",
                     bus.occupancy, bus.out_valid);
        end
        @(posedge clk);
        #1;
        arst = 1'b0;
        push_e(P, 0, 0, 16'd0, 0, 8'd70);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'd70) begin
            errors++;
            $display("FAIL post_flush: ov=%0b tag=%0d want 1/70",
                     bus.out_valid, bus.out_tag);
        end
        exp_q.push_back('{P, 8'd70, 1'b0});
        drain("post_flush_pop");
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.credit_ok = 3'b111;
        push_e(P, 0, 0, 16'd0, 0, 8'd80);
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_class    = P;
        bus.in_tag      = 8'd81;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'd80) begin
            errors++;
            $display("FAIL b2b_grant: ov=%0b tag=%0d want 1/80",
                     bus.out_valid, bus.out_tag);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.occupancy !== 4'd1 || bus.out_tag !== 8'd81) begin
            errors++;
            $display("FAIL b2b_state: occ=%0d tag=%0d want 1/81",
                     bus.occupancy, bus.out_tag);
        end
        exp_q.push_back('{P, 8'd81, 1'b0});
        drain("b2b_tail");
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_bypass !== 1'b0) begin
            errors++;
            $display("FAIL empty: ov=%0b byp=%0b want 0/0",
                     bus.out_valid, bus.out_bypass);
        end
    endtask

    initial begin
        bus.credit_ok = 3'b111;
        idle_inputs();
        #1;
        test_reset();
        test_in_order();
        test_credit_bypass();
        test_cpl_order();
        test_cpl_pass_posted();
        test_max_bypass();
        test_full_middle();
        test_reset_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
